exc_ctrl: RTL

- Exception/return sequencer for the WISC-SP22 pipeline; handles the SIIC (00010) and RTI (00011) opcodes and illegal-opcode errors flagged by the decoder.
- Sits beside the decode stage.
- On an exception it:
  - saves the EPC and the cause;
  - stalls and flushes the front end;
  - waits for the pipeline to drain;
  - redirects fetch to the handler.
- On RTI it redirects fetch back to the saved EPC.

---
 rtl/exc_pkg.sv | 19 +
 rtl/exc_drain_timer.sv | 34 +++
 rtl/exc_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/exc_pkg.sv
// Shared state encoding, cause codes and opcodes for the exception/return sequencer.
package exc_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DRAIN    = 2'd1,
      REDIRECT = 2'd2,
      HALTED   = 2'd3
   } exc_state_e;

   localparam logic [1:0] CAUSE_NONE  = 2'b00;
   localparam logic [1:0] CAUSE_SIIC  = 2'b01;
   localparam logic [1:0] CAUSE_ILL   = 2'b10;
   localparam logic [1:0] CAUSE_FATAL = 2'b11;

   localparam logic [4:0] OP_SIIC = 5'b00010;
   localparam logic [4:0] OP_RTI  = 5'b00011;

endpackage

// File: rtl/exc_drain_timer.sv
// Saturating drain-cycle counter; done once MIN_DRAIN cycles have been counted.
module exc_drain_timer #(
   parameter int MIN_DRAIN = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic done_o
);

   localparam logic [2:0] SAT = 3'(MIN_DRAIN);

   logic [2:0] count_q;
   logic [2:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i)
         count_d = '0;
      else if (en_i && (count_q < SAT))
         count_d = count_q + 3'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign done_o = (count_q >= SAT);

endmodule

// File: rtl/exc_ctrl.sv
// Exception/return sequencer beside decode: SIIC, RTI and illegal-opcode handling.
// Optional EXC_COUNT_EN adds a saturating 16-bit exception counter output.
module exc_ctrl
   import exc_pkg::*;
#(
   parameter int              PC_W         = 16,
   parameter logic [PC_W-1:0] HANDLER_ADDR = PC_W'(16'h0002),
   parameter int              MIN_DRAIN    = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_valid,
   input  logic [4:0]      id_opcode,
   input  logic            id_err,
   input  logic [PC_W-1:0] id_pc,
   input  logic [PC_W-1:0] id_pc_inc,
   input  logic            pipe_empty,
   output logic            stall_out,
   output logic            flush_out,
   output logic            redirect_valid,
   output logic [PC_W-1:0] redirect_pc,
   output logic [PC_W-1:0] epc_out,
   output logic [1:0]      exc_cause,
   output logic            in_handler,
`ifdef EXC_COUNT_EN
   output logic [15:0]     exc_count,
`endif
   output logic            halt_req
);

   exc_state_e      state_q;
   logic            stall_q, flush_q, redirect_q, in_handler_q, halt_q, from_exc_q;
   logic [PC_W-1:0] tgt_q, epc_q;
   logic [1:0]      cause_q;

   logic ev_ill, ev_siic, ev_exc, ev_rti, idle, timer_en, drain_done;

   // Illegal beats SIIC; RTI only counts as a return while the handler runs.
   assign ev_ill   = id_valid && id_err;
   assign ev_siic  = id_valid && !id_err && (id_opcode == OP_SIIC);
   assign ev_exc   = ev_ill || ev_siic;
   assign ev_rti   = id_valid && !id_err && (id_opcode == OP_RTI) && in_handler_q;
   assign idle     = (state_q == IDLE);

   // Counting starts on the entry edge so the redirect lands MIN_DRAIN+1 cycles after the event.
   assign timer_en = (idle && ((ev_exc && !in_handler_q) || ev_rti)) || (state_q == DRAIN);

   exc_drain_timer #(.MIN_DRAIN(MIN_DRAIN)) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (!timer_en),
      .en_i   (timer_en),
      .done_o (drain_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         stall_q      <= 1'b0;
         flush_q      <= 1'b0;
         redirect_q   <= 1'b0;
         in_handler_q <= 1'b0;
         halt_q       <= 1'b0;
         from_exc_q   <= 1'b0;
         tgt_q        <= '0;
         epc_q        <= '0;
         cause_q      <= CAUSE_NONE;
      end else begin
         flush_q    <= 1'b0;
         redirect_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (ev_exc && in_handler_q) begin
                  state_q <= HALTED;
                  cause_q <= CAUSE_FATAL;
                  halt_q  <= 1'b1;
                  stall_q <= 1'b1;
               end else if (ev_exc) begin
                  state_q    <= DRAIN;
                  stall_q    <= 1'b1;
                  flush_q    <= 1'b1;
                  tgt_q      <= HANDLER_ADDR;
                  from_exc_q <= 1'b1;
                  epc_q      <= ev_ill ? id_pc : id_pc_inc;
                  cause_q    <= ev_ill ? CAUSE_ILL : CAUSE_SIIC;
               end else if (ev_rti) begin
                  state_q    <= DRAIN;
                  stall_q    <= 1'b1;
                  flush_q    <= 1'b1;
                  tgt_q      <= epc_q;
                  from_exc_q <= 1'b0;
               end
            end
            DRAIN: begin
               if (drain_done && pipe_empty) begin
                  state_q    <= REDIRECT;
                  stall_q    <= 1'b0;
                  redirect_q <= 1'b1;
               end
            end
            REDIRECT: begin
               in_handler_q <= from_exc_q;
               if (!from_exc_q)
                  cause_q <= CAUSE_NONE;
               state_q <= IDLE;
            end
            default: begin
               stall_q <= 1'b1;
               halt_q  <= 1'b1;
            end
         endcase
      end
   end

`ifdef EXC_COUNT_EN
   logic [15:0] exc_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         exc_count_q <= '0;
      else if (idle && ev_exc && (exc_count_q != 16'hFFFF))
         exc_count_q <= exc_count_q + 16'd1;
   end

   assign exc_count = exc_count_q;
`endif

   assign stall_out      = stall_q;
   assign flush_out      = flush_q;
   assign redirect_valid = redirect_q;
   assign redirect_pc    = tgt_q;
   assign epc_out        = epc_q;
   assign exc_cause      = cause_q;
   assign in_handler     = in_handler_q;
   assign halt_req       = halt_q;

endmodule
